// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - serializes single-word accesses from NREQ requesters onto a shared DFF bank
// Round-robin by default; define DFF_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LW-1:0]    r_last;
  logic [LW-1:0]    w_win;
  logic             w_any;
  logic             w_take;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic [WIDTH-1:0] r_bank [DEPTH];
  logic [AW-1:0]    w_addr_a  [NREQ];
  logic [WIDTH-1:0] w_wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_a[g]  = addr[g*AW +: AW];
    assign w_wdata_a[g] = wdata[g*WIDTH +: WIDTH];
  end

  function automatic logic [LW-1:0] f_wrap(input int v);
    f_wrap = LW'(v % NREQ);
  endfunction

  assign w_any  = |req;
  assign w_take = (r_state == S_IDLE) && w_any;

  // Scan from the farthest candidate to the nearest so the nearest asserted one wins.
  always_comb begin
    w_win = '0;
`ifdef DFF_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[f_wrap(i)]) w_win = f_wrap(i);
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      if (req[f_wrap(int'(r_last) + k)]) w_win = f_wrap(int'(r_last) + k);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_GRANT;
      S_GRANT: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last   <= LW'(NREQ - 1);
      r_gnt    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= 1'b0;
      if (w_take) begin
        r_gnt   <= NREQ'(1) << w_win;
        r_last  <= w_win;
        r_we    <= we[w_win];
        r_addr  <= w_addr_a[w_win];
        r_wdata <= w_wdata_a[w_win];
      end
      if (r_state == S_GRANT) begin
        if (r_we) begin
          r_bank[r_addr] <= r_wdata;
        end else begin
          r_rdata  <= r_bank[r_addr];
          r_rvalid <= 1'b1;
        end
      end
    end
  end

  assign gnt    = r_gnt;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - scoreboard bench for dff_bank_arbiter with a transaction-level reference model
module tb_dff_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct { int val; int cyc; } ev_t;

  logic                  clk   = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req   = '0;
  logic [NREQ-1:0]       we    = '0;
  logic [NREQ*AW-1:0]    addr  = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic                  busy;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  ev_t g_q[$];
  ev_t rd_q[$];
  ev_t g_log[$];
  int  obs_rd     = -1;
  int  obs_rd_cyc = -1;

  // Reference model: arbiter is free again 3 edges after a grant; the access lands on the edge after the grant.
  int               m_left = 0;
  int               m_last = NREQ - 1;
  logic [WIDTH-1:0] m_bank [DEPTH];
  logic [WIDTH-1:0] m_rdata = '0;
  bit               m_we;
  int               m_a;
  int               m_d;

  bit act     [NREQ];
  bit auto_en [NREQ];
  bit t_we    [NREQ];
  int t_addr  [NREQ];
  int t_wd    [NREQ];
  int prob = 100;

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act_v, exp_v, cyc);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef DFF_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return 0;
  endfunction

  task automatic rand_txn(input int i);
    t_we[i]   = 1'($urandom_range(1, 0));
    t_addr[i] = int'($urandom_range(DEPTH - 1, 0));
    t_wd[i]   = int'($urandom_range(255, 0));
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) act[i] = 1'b0;
      else if (!act[i] && auto_en[i] && $urandom_range(99, 0) < prob) begin
        act[i] = 1'b1;
        rand_txn(i);
      end
      req[i] = act[i];
      we[i]  = t_we[i];
      addr[i*AW +: AW]        = t_addr[i][AW-1:0];
      wdata[i*WIDTH +: WIDTH] = t_wd[i][WIDTH-1:0];
    end
  endtask

  task automatic wait_grant(input int i);
    for (int n = 0; n < 30 && act[i]; n++) tick();
    check("grant_timeout", 32'(act[i]), 0);
  endtask

  task automatic do_access(input int i, input bit w, input int a, input int d);
    t_we[i] = w; t_addr[i] = a; t_wd[i] = d; act[i] = 1'b1;
    obs_rd = -1;
    wait_grant(i);
    tick();
    tick();
  endtask

  task automatic drain();
    bit pend;
    for (int i = 0; i < NREQ; i++) auto_en[i] = 1'b0;
    for (int n = 0; n < 60; n++) begin
      pend = busy;
      for (int i = 0; i < NREQ; i++) pend = pend | act[i];
      if (!pend) break;
      tick();
    end
    check("drain_idle", 32'(pend), 0);
  endtask

  task automatic start_from_reset(input logic [NREQ-1:0] who);
    tick();
    #1 reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      act[i] = who[i]; auto_en[i] = who[i];
      rand_txn(i);
    end
    prob = 100;
    tick();
    tick();
    #1 reset = 1'b1;
    g_log.delete();
  endtask

  task automatic collect(input int n);
    for (int k = 0; k < 80 && g_log.size() < n; k++) tick();
    check("collect_count", 32'(g_log.size() >= n), 1);
  endtask

  initial begin : model
    int w;
    ev_t e;
    for (int i = 0; i < DEPTH; i++) m_bank[i] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        m_left = 0; m_last = NREQ - 1; m_rdata = '0;
        for (int i = 0; i < DEPTH; i++) m_bank[i] = '0;
      end else if (m_left == 2) begin
        if (m_we) m_bank[m_a] = m_d[WIDTH-1:0];
        else begin
          m_rdata = m_bank[m_a];
          e.val = int'(m_rdata); e.cyc = cyc;
          rd_q.push_back(e);
        end
        m_left = 1;
      end else if (m_left == 1) begin
        m_left = 0;
      end else if (req != '0) begin
        w = pick(req, m_last);
        e.val = w; e.cyc = cyc;
        g_q.push_back(e);
        m_we = we[w];
        m_a  = int'(addr[w*AW +: AW]);
        m_d  = int'(wdata[w*WIDTH +: WIDTH]);
        m_last = w;
        m_left = 2;
      end
    end
  end

  initial begin : monitor
    ev_t e;
    ev_t o;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_busy", 32'(busy), 0);
      end else begin
        check("busy", 32'(busy), 32'(m_left != 0));
        check("rdata_hold", 32'(rdata), 32'(m_rdata));
        if (gnt != '0) begin
          if (g_q.size() == 0) check("gnt_spurious", 32'(gnt), 0);
          else begin
            e = g_q.pop_front();
            check("gnt_who", 32'(gnt), 32'(1) << e.val);
            check("gnt_cycle", cyc, e.cyc);
          end
          o.val = -1; o.cyc = cyc;
          for (int i = NREQ - 1; i >= 0; i--) if (gnt[i]) o.val = i;
          g_log.push_back(o);
        end
        if (rvalid) begin
          if (rd_q.size() == 0) check("rvalid_spurious", 32'(rvalid), 0);
          else begin
            e = rd_q.pop_front();
            check("rdata", 32'(rdata), e.val);
            check("rvalid_cycle", cyc, e.cyc);
          end
          obs_rd = int'(rdata); obs_rd_cyc = cyc;
        end
      end
    end
  end

  initial begin : stim
    int gc;
    for (int i = 0; i < NREQ; i++) begin act[i] = $urandom_range(1, 0) != 0; rand_txn(i); end
    tick();
    tick();
    check("reset_gnt", 32'(gnt), 0);
    check("reset_busy", 32'(busy), 0);
    for (int i = 0; i < NREQ; i++) act[i] = 1'b0;
    tick();
    #1 reset = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      do_access(0, 1'b0, a, 0);
      check("reset_read_zero", obs_rd, 0);
    end

    do_access(0, 1'b1, 2, 'hA5);
    check("wr_gnt_req0", g_log[g_log.size()-1].val, 0);
    do_access(1, 1'b0, 2, 0);
    gc = g_log[g_log.size()-1].cyc;
    check("rd_gnt_req1", g_log[g_log.size()-1].val, 1);
    check("raw_rdata", obs_rd, 'hA5);
    check("raw_latency", obs_rd_cyc - gc, 1);

`ifdef DFF_ARB_FIXED_PRIO_EN
    start_from_reset(4'b1010);
    collect(5);
    for (int j = 0; j < g_log.size() && j < 5; j++) check("fixed_only_req1", g_log[j].val, 1);
    for (int j = 1; j < g_log.size() && j < 5; j++) check("fixed_spacing", g_log[j].cyc - g_log[j-1].cyc, 3);
    drain();
`else
    start_from_reset(4'b1111);
    collect(6);
    for (int j = 0; j < g_log.size() && j < 6; j++) check("cont_order", g_log[j].val, j % 4);
    for (int j = 1; j < g_log.size() && j < 6; j++) check("cont_spacing", g_log[j].cyc - g_log[j-1].cyc, 3);
    drain();

    start_from_reset(4'b0101);
    collect(8);
    for (int j = 0; j < g_log.size() && j < 8; j++) check("fair_order", g_log[j].val, (j % 2) * 2);
    drain();
`endif

    t_we[0] = 1'b1; t_addr[0] = 1; t_wd[0] = 'h3C; act[0] = 1'b1;
    wait_grant(0);
    #2 reset = 1'b0;
    #1;
    check("midrst_gnt_drop", 32'(gnt), 0);
    check("midrst_busy", 32'(busy), 0);
    tick();
    tick();
    #1 reset = 1'b1;
    do_access(2, 1'b0, 1, 0);
    check("midrst_read_addr1", obs_rd, 0);

    for (int i = 0; i < NREQ; i++) auto_en[i] = 1'b1;
    prob = 35;
    for (int n = 0; n < 300; n++) tick();
    drain();
    tick();
    tick();

    check("sb_gnt_left", g_q.size(), 0);
    check("sb_rd_left", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Arbitrates a small bank of D flip-flop storage registers shared by up to NREQ requesters. Each requester issues a single-word read or write through a req/gnt handshake. The arbiter serializes the accesses with round-robin priority and returns read data with a valid strobe. It sits between the control blocks and the shared flip-flop bank, and it owns that bank.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- WIDTH, 8, data width of each bank register
- DEPTH, 4, number of bank registers (power of two, ≥2); AW = $clog2(DEPTH)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester access request
- we  in  NREQ  per-requester write enable (1 = write, 0 = read)
- addr  in  NREQ*AW  per-requester register address, requester i at [i*AW +: AW]
- wdata  in  NREQ*WIDTH  per-requester write data, requester i at [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, one-cycle pulse
- rdata  out  WIDTH  read data of the last granted read
- rvalid  out  1  rdata valid strobe, one cycle
- busy  out  1  high whenever FSM is not IDLE

## Operation
- FSM states: IDLE, GRANT, DONE.
- IDLE:
  - If any req bit is high, select winner w by round-robin, searching from last+1 upward with wrap.
  - Capture we[w], addr[w] and wdata[w].
  - Set gnt[w] and last = w, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - gnt is high for exactly this cycle.
  - Write: bank[addr] <= wdata at the end of the cycle.
  - Read: rdata <= bank[addr]; rvalid is set for the next cycle.
  - Clear gnt and go to DONE.
- DONE:
  - rvalid is high only if the access was a read. rdata holds its value until the next read.
  - No arbitration takes place. Return to IDLE.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees its gnt.
  - It deasserts req on the edge that ends the gnt cycle.
  - If req is still high in IDLE after DONE, it is treated as a new request.
- Requests that appear while the FSM is in GRANT or DONE are held off until IDLE. They are never lost as long as req is held.
- Read-after-write to the same address always returns the new value, because accesses are fully serialized.
- busy = (state != IDLE).
- Reset values:
  - gnt = 0, rdata = 0, rvalid = 0, busy = 0.
  - All bank registers = 0.
  - state = IDLE.
  - last = NREQ-1, so requester 0 has first priority after reset.
- When reset is asserted mid-operation, all state and outputs take their reset values immediately. Any pending write is discarded and the bank is not modified.

## Timing
- req[i] is sampled high in IDLE at edge k.
- gnt[i] is high from edge k to edge k+1.
- For a write, the bank is updated at edge k+1.
- For a read, rvalid and rdata are valid from edge k+1 to edge k+2.
- Latency from the req-sampling edge to rvalid is 1 cycle. The FSM is back in IDLE after edge k+2.
- Peak throughput is one access per 3 cycles.
- Reset is asynchronous on assert. Deassertion is expected to be synchronized externally to clk.

## Configuration
- Macro: DFF_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index asserted req always wins. last is not used for selection, and starvation of higher indices is permitted.
- Undefined (default): round-robin as described above.

## Test plan
- Reset: hold reset=0 for 20 ns with random req. Expect gnt=0, rvalid=0, rdata=0, busy=0. After release, a read of every address returns 0.
- Write then read: requester 0 writes addr=2, wdata=8'hA5. Expect gnt=4'b0001 for one cycle. Then requester 1 reads addr=2. Expect gnt=4'b0010, then rvalid=1 with rdata=8'hA5 exactly one cycle later.
- Full contention: all four req asserted together from reset and each re-requests after its grant. Expect grant order 0,1,2,3,0,1, with grants spaced 3 cycles apart.
- Fairness: req0 and req2 held continuously (re-asserted after each grant). Expect grants to alternate 0,2,0,2 and requesters 1 and 3 never granted.
- Mid-access reset: assert reset during the GRANT cycle of a write of 8'h3C to addr 1. Expect gnt to drop immediately. After release, a read of addr 1 returns 8'h00.
- With DFF_ARB_FIXED_PRIO_EN defined: req1 and req3 held continuously. Expect only requester 1 granted (every 3 cycles) and requester 3 never granted.
